// File: rtl/ccip_mmio_rd_router.sv
// MMIO read router for one CCI-P tree level. Requests are steered to a sub-AFU
// by address window. Each port's outstanding reads are tracked in order, and the
// c2 responses are merged back upstream. Reads that cannot be served (unmapped
// window, no credit, or timed out) get an all-ones reply so the host never stalls.
module ccip_mmio_rd_router #(
  parameter int NUM_SUB_AFUS      = 4,
  parameter int WINDOW_BITS       = 12,
  parameter int OUTSTANDING_DEPTH = 8,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                       pClk,
  input  logic                       SoftReset_n,
  input  logic                       up_rd_valid,
  input  logic [8:0]                 up_rd_tid,
  input  logic [15:0]                up_rd_addr,
  output logic [NUM_SUB_AFUS-1:0]    sub_rd_valid,
  output logic [8:0]                 sub_rd_tid,
  output logic [15:0]                sub_rd_addr,
  input  logic [NUM_SUB_AFUS-1:0]    sub_rsp_valid,
  input  logic [NUM_SUB_AFUS*9-1:0]  sub_rsp_tid,
  input  logic [NUM_SUB_AFUS*64-1:0] sub_rsp_data,
  output logic                       up_rsp_valid,
  output logic [8:0]                 up_rsp_tid,
  output logic [63:0]                up_rsp_data,
  output logic                       err_unmapped,
  output logic                       err_overflow,
  output logic [NUM_SUB_AFUS-1:0]    err_timeout,
  output logic [NUM_SUB_AFUS-1:0]    err_tid_mismatch
);

  localparam int PW = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1;
  localparam int AW = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [63:0] ALL_ONES = '1;

  // Per-port outstanding-tid FIFO
  logic [8:0]    oqMem [NUM_SUB_AFUS][OUTSTANDING_DEPTH];
  logic [AW-1:0] oqRd  [NUM_SUB_AFUS];
  logic [AW-1:0] oqWr  [NUM_SUB_AFUS];
  logic [CW-1:0] oqCnt [NUM_SUB_AFUS];

  // Per-port response FIFO, {tid, data}
  logic [72:0]   rqMem [NUM_SUB_AFUS][OUTSTANDING_DEPTH];
  logic [AW-1:0] rqRd  [NUM_SUB_AFUS];
  logic [AW-1:0] rqWr  [NUM_SUB_AFUS];
  logic [CW-1:0] rqCnt [NUM_SUB_AFUS];

  // Head-of-queue age per port
  logic [TW-1:0] tc [NUM_SUB_AFUS];

  // Synthetic all-ones response queue (at most one entry in and out per cycle)
  logic [72:0] sqMem [2];
  logic        sqRd;
  logic        sqWr;
  logic [1:0]  sqCnt;

  logic [PW-1:0] rrPtr;

  logic [15:0]   reqIdx;
  logic          reqMapped;
  logic [PW-1:0] reqPort;
  logic          fwd;
  logic          sqPush;

  logic [NUM_SUB_AFUS-1:0] hasCredit;
  logic [NUM_SUB_AFUS-1:0] rspMatch;
  logic [NUM_SUB_AFUS-1:0] toFire;
  logic [NUM_SUB_AFUS-1:0] oqPop;
  logic [NUM_SUB_AFUS-1:0] oqPush;
  logic [NUM_SUB_AFUS-1:0] rqPop;
  logic [8:0]              oqHead [NUM_SUB_AFUS];
  logic [72:0]             rqIn   [NUM_SUB_AFUS];

  logic          grantValid;
  logic          grantSq;
  logic [PW-1:0] grantPort;
  logic [72:0]   grantData;
  logic [PW-1:0] nextPtr;

  assign reqIdx    = up_rd_addr >> WINDOW_BITS;
  assign reqMapped = (reqIdx < 16'(NUM_SUB_AFUS));
  assign reqPort   = reqIdx[PW-1:0];
  assign fwd       = up_rd_valid && reqMapped && hasCredit[reqPort];
  assign sqPush    = up_rd_valid && !fwd;
  assign oqPush    = fwd ? (NUM_SUB_AFUS'(1) << reqPort) : '0;

  // Credit, in-order response validation and timeout detection for each port
  always_comb begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      oqHead[i]    = oqMem[i][oqRd[i]];
      hasCredit[i] = ({1'b0, oqCnt[i]} + {1'b0, rqCnt[i]}) < OW'(OUTSTANDING_DEPTH);
      rspMatch[i]  = sub_rsp_valid[i] && (oqCnt[i] != '0) &&
                     (sub_rsp_tid[9*i +: 9] == oqHead[i]);
      toFire[i]    = (oqCnt[i] != '0) && (tc[i] == TW'(TIMEOUT_CYCLES - 1)) && !rspMatch[i];
      oqPop[i]     = rspMatch[i] || toFire[i];
      rqIn[i]      = rspMatch[i] ? {sub_rsp_tid[9*i +: 9], sub_rsp_data[64*i +: 64]}
                                 : {oqHead[i], ALL_ONES};
    end
  end

  // Merge arbitration: synthetic queue first, then round-robin over response FIFOs
  always_comb begin
    int cand;
    cand       = 0;
    grantValid = 1'b0;
    grantSq    = 1'b0;
    grantPort  = '0;
    grantData  = '0;
    rqPop      = '0;
    if (sqCnt != '0) begin
      grantValid = 1'b1;
      grantSq    = 1'b1;
      grantData  = sqMem[sqRd];
    end else begin
      for (int k = 0; k < NUM_SUB_AFUS; k++) begin
        cand = int'(rrPtr) + k;
        if (cand >= NUM_SUB_AFUS) cand = cand - NUM_SUB_AFUS;
        if (!grantValid && (rqCnt[cand] != '0)) begin
          grantValid = 1'b1;
          grantPort  = PW'(cand);
          grantData  = rqMem[cand][rqRd[cand]];
        end
      end
      if (grantValid) rqPop[grantPort] = 1'b1;
    end
  end

  assign nextPtr = (grantPort == PW'(NUM_SUB_AFUS - 1)) ? '0 : grantPort + PW'(1);

  // FIFO storage writes; contents are ignored whenever the matching count is zero
  always_ff @(posedge pClk) begin
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      if (oqPush[i]) oqMem[i][oqWr[i]] <= up_rd_tid;
      if (oqPop[i])  rqMem[i][rqWr[i]] <= rqIn[i];
    end
    if (sqPush) sqMem[sqWr] <= {up_rd_tid, ALL_ONES};
  end

  // FIFO pointers, occupancy counts and head-age counters
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        oqRd[i]  <= '0;
        oqWr[i]  <= '0;
        oqCnt[i] <= '0;
        rqRd[i]  <= '0;
        rqWr[i]  <= '0;
        rqCnt[i] <= '0;
        tc[i]    <= '0;
      end
      sqRd  <= 1'b0;
      sqWr  <= 1'b0;
      sqCnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        if (oqPush[i]) oqWr[i] <= oqWr[i] + AW'(1);
        if (oqPop[i])  oqRd[i] <= oqRd[i] + AW'(1);
        oqCnt[i] <= oqCnt[i] + CW'(oqPush[i]) - CW'(oqPop[i]);
        if (oqPop[i])  rqWr[i] <= rqWr[i] + AW'(1);
        if (rqPop[i])  rqRd[i] <= rqRd[i] + AW'(1);
        rqCnt[i] <= rqCnt[i] + CW'(oqPop[i]) - CW'(rqPop[i]);
        if (oqPop[i] || (oqCnt[i] == '0)) tc[i] <= '0;
        else                              tc[i] <= tc[i] + TW'(1);
      end
      if (sqPush)  sqWr <= ~sqWr;
      if (grantSq) sqRd <= ~sqRd;
      sqCnt <= sqCnt + 2'(sqPush) - 2'(grantSq);
    end
  end

  // Registered request forward, merged response output, RR pointer and error pulses
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      sub_rd_valid     <= '0;
      sub_rd_tid       <= '0;
      sub_rd_addr      <= '0;
      up_rsp_valid     <= 1'b0;
      up_rsp_tid       <= '0;
      up_rsp_data      <= '0;
      err_unmapped     <= 1'b0;
      err_overflow     <= 1'b0;
      err_timeout      <= '0;
      err_tid_mismatch <= '0;
      rrPtr            <= '0;
    end else begin
      sub_rd_valid <= oqPush;
      if (fwd) begin
        sub_rd_tid  <= up_rd_tid;
        sub_rd_addr <= 16'(up_rd_addr[WINDOW_BITS-1:0]);
      end
      up_rsp_valid <= grantValid;
      if (grantValid) begin
        up_rsp_tid  <= grantData[72:64];
        up_rsp_data <= grantData[63:0];
      end
      if (grantValid && !grantSq) rrPtr <= nextPtr;
      err_unmapped     <= up_rd_valid && !reqMapped;
      err_overflow     <= up_rd_valid && reqMapped && !fwd;
      err_timeout      <= toFire;
      err_tid_mismatch <= sub_rsp_valid & ~rspMatch;
    end
  end

endmodule

// File: tb/tb_ccip_mmio_rd_router.sv
// Bench for ccip_mmio_rd_router: directed test-plan steps followed by a random
// phase. Every cycle is checked against a queue-based reference model.
module tb_ccip_mmio_rd_router;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int WB = 12;
  localparam int DP = 8;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  logic          pClk;
  logic          SoftReset_n;
  logic          up_rd_valid;
  logic [8:0]    up_rd_tid;
  logic [15:0]   up_rd_addr;
  logic [N-1:0]  sub_rd_valid;
  logic [8:0]    sub_rd_tid;
  logic [15:0]   sub_rd_addr;
  logic [N-1:0]  sub_rsp_valid;
  logic [N*9-1:0]  sub_rsp_tid;
  logic [N*64-1:0] sub_rsp_data;
  logic          up_rsp_valid;
  logic [8:0]    up_rsp_tid;
  logic [63:0]   up_rsp_data;
  logic          err_unmapped;
  logic          err_overflow;
  logic [N-1:0]  err_timeout;
  logic [N-1:0]  err_tid_mismatch;

  ccip_mmio_rd_router #(
    .NUM_SUB_AFUS(N), .WINDOW_BITS(WB), .OUTSTANDING_DEPTH(DP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pClk(pClk), .SoftReset_n(SoftReset_n),
    .up_rd_valid(up_rd_valid), .up_rd_tid(up_rd_tid), .up_rd_addr(up_rd_addr),
    .sub_rd_valid(sub_rd_valid), .sub_rd_tid(sub_rd_tid), .sub_rd_addr(sub_rd_addr),
    .sub_rsp_valid(sub_rsp_valid), .sub_rsp_tid(sub_rsp_tid), .sub_rsp_data(sub_rsp_data),
    .up_rsp_valid(up_rsp_valid), .up_rsp_tid(up_rsp_tid), .up_rsp_data(up_rsp_data),
    .err_unmapped(err_unmapped), .err_overflow(err_overflow),
    .err_timeout(err_timeout), .err_tid_mismatch(err_tid_mismatch)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: plain queues, head arrival cycle per port, RR index
  logic [8:0] mOq [N][$];
  rsp_t       mRq [N][$];
  rsp_t       mSq [$];
  int         mHead [N];
  int         mRr = 0;

  // Expected registered outputs after the coming edge
  logic [N-1:0] eSubValid;
  logic [8:0]   eSubTid;
  logic [15:0]  eSubAddr;
  logic         eRspValid;
  logic [8:0]   eRspTid;
  logic [63:0]  eRspData;
  logic         eUnm;
  logic         eOvf;
  logic [N-1:0] eTo;
  logic [N-1:0] eMis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    int   oqPre [N];
    int   occ [N];
    bit   popped;
    rsp_t r;
    logic [8:0] t;
    int   idx;
    eSubValid = '0; eSubTid = '0; eSubAddr = '0;
    eRspValid = 1'b0; eRspTid = '0; eRspData = '0;
    eUnm = 1'b0; eOvf = 1'b0; eTo = '0; eMis = '0;
    if (!SoftReset_n) begin
      for (int i = 0; i < N; i++) begin
        mOq[i].delete();
        mRq[i].delete();
      end
      mSq.delete();
      mRr = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        oqPre[i] = mOq[i].size();
        occ[i]   = mOq[i].size() + mRq[i].size();
      end
      if (mSq.size() > 0) begin
        r = mSq.pop_front();
        eRspValid = 1'b1; eRspTid = r.tid; eRspData = r.data;
      end else begin
        for (int k = 0; k < N; k++) begin
          int p;
          p = (mRr + k) % N;
          if (!eRspValid && mRq[p].size() > 0) begin
            r = mRq[p].pop_front();
            eRspValid = 1'b1; eRspTid = r.tid; eRspData = r.data;
            mRr = (p + 1) % N;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        popped = 1'b0;
        if (sub_rsp_valid[i]) begin
          t = sub_rsp_tid[9*i +: 9];
          if (oqPre[i] > 0 && mOq[i][0] == t) begin
            void'(mOq[i].pop_front());
            r.tid = t; r.data = sub_rsp_data[64*i +: 64];
            mRq[i].push_back(r);
            popped = 1'b1;
          end else begin
            eMis[i] = 1'b1;
          end
        end
        if (!popped && oqPre[i] > 0 && (cyc - mHead[i]) == TO - 1) begin
          r.tid = mOq[i].pop_front(); r.data = '1;
          mRq[i].push_back(r);
          eTo[i] = 1'b1;
          popped = 1'b1;
        end
        if (popped) mHead[i] = cyc + 1;
      end
      if (up_rd_valid) begin
        idx = int'(up_rd_addr >> WB);
        r.tid = up_rd_tid; r.data = '1;
        if (idx >= N) begin
          mSq.push_back(r);
          eUnm = 1'b1;
        end else if (occ[idx] >= DP) begin
          mSq.push_back(r);
          eOvf = 1'b1;
        end else begin
          eSubValid = N'(1 << idx);
          eSubTid   = up_rd_tid;
          eSubAddr  = up_rd_addr & 16'h0FFF;
          if (oqPre[idx] == 0) mHead[idx] = cyc + 1;
          mOq[idx].push_back(up_rd_tid);
        end
      end
    end
  endtask

  task automatic checkOutputs();
    chk("sub_rd_valid", sub_rd_valid, eSubValid);
    if (eSubValid != '0) begin
      chk("sub_rd_tid", sub_rd_tid, eSubTid);
      chk("sub_rd_addr", sub_rd_addr, eSubAddr);
    end
    chk("up_rsp_valid", up_rsp_valid, eRspValid);
    if (eRspValid) begin
      chk("up_rsp_tid", up_rsp_tid, eRspTid);
      chk("up_rsp_data", up_rsp_data, eRspData);
    end
    chk("err_unmapped", err_unmapped, eUnm);
    chk("err_overflow", err_overflow, eOvf);
    chk("err_timeout", err_timeout, eTo);
    chk("err_tid_mismatch", err_tid_mismatch, eMis);
    if (!SoftReset_n) begin
      chk("rst_sub_rd_tid", sub_rd_tid, 64'd0);
      chk("rst_sub_rd_addr", sub_rd_addr, 64'd0);
      chk("rst_up_rsp_tid", up_rsp_tid, 64'd0);
      chk("rst_up_rsp_data", up_rsp_data, 64'd0);
    end
  endtask

  task automatic step();
    modelEdge();
    @(posedge pClk);
    #1;
    checkOutputs();
    cyc++;
  endtask

  task automatic clearInputs();
    up_rd_valid   = 1'b0;
    up_rd_tid     = '0;
    up_rd_addr    = '0;
    sub_rsp_valid = '0;
    sub_rsp_tid   = '0;
    sub_rsp_data  = '0;
  endtask

  task automatic randomInputs();
    up_rd_valid   = 1'($urandom);
    up_rd_tid     = 9'($urandom);
    up_rd_addr    = 16'($urandom);
    sub_rsp_valid = N'($urandom);
    sub_rsp_tid   = 36'({$urandom(), $urandom()});
    for (int i = 0; i < N; i++) sub_rsp_data[64*i +: 64] = {$urandom(), $urandom()};
  endtask

  task automatic upRead(input logic [8:0] tid, input logic [15:0] addr);
    up_rd_valid = 1'b1;
    up_rd_tid   = tid;
    up_rd_addr  = addr;
  endtask

  task automatic subRsp(input int port, input logic [8:0] tid, input logic [63:0] data);
    sub_rsp_valid[port]         = 1'b1;
    sub_rsp_tid[9*port +: 9]    = tid;
    sub_rsp_data[64*port +: 64] = data;
  endtask

  task automatic pulseReset();
    clearInputs();
    SoftReset_n = 1'b0;
    step();
    step();
    SoftReset_n = 1'b1;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int rspPct;
    for (int i = 0; i < N; i++) mHead[i] = 0;
    clearInputs();
    SoftReset_n = 1'b0;

    // Reset held with inputs toggling
    for (int k = 0; k < 6; k++) begin
      randomInputs();
      step();
    end
    clearInputs();
    SoftReset_n = 1'b1;
    step();

    // Forward to port 1 with window-relative address, then its response
    upRead(9'h005, 16'h1010);
    step();
    chk("plan_fwd_onehot", sub_rd_valid, 64'h2);
    chk("plan_fwd_addr", sub_rd_addr, 64'h0010);
    clearInputs();
    step();
    chk("plan_fwd_one_cycle", sub_rd_valid, 64'h0);
    subRsp(1, 9'h005, 64'h0123_4567_89AB_CDEF);
    step();
    clearInputs();
    step();
    chk("plan_rsp_tid", up_rsp_tid, 64'h005);
    chk("plan_rsp_data", up_rsp_data, 64'h0123_4567_89AB_CDEF);

    // Round-robin: four simultaneous responses from a fresh pointer
    pulseReset();
    for (int i = 0; i < N; i++) begin
      upRead(9'(i + 1), 16'(i << WB));
      step();
    end
    clearInputs();
    step();
    for (int i = 0; i < N; i++) subRsp(i, 9'(i + 1), 64'(64'hA000 + i));
    step();
    clearInputs();
    for (int k = 0; k < N; k++) begin
      step();
      chk("plan_rr_tid", up_rsp_tid, 64'(k + 1));
    end

    // Unmapped window
    upRead(9'h1AB, 16'h5000);
    step();
    chk("plan_unmapped_err", err_unmapped, 64'h1);
    clearInputs();
    step();
    chk("plan_unmapped_tid", up_rsp_tid, 64'h1AB);
    chk("plan_unmapped_data", up_rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Credit overflow on port 0
    pulseReset();
    for (int k = 0; k < DP; k++) begin
      upRead(9'(9'h040 + k), 16'(k));
      step();
    end
    upRead(9'h048, 16'h0008);
    step();
    chk("plan_overflow_err", err_overflow, 64'h1);
    chk("plan_overflow_nofwd", sub_rd_valid, 64'h0);
    clearInputs();
    step();
    chk("plan_overflow_tid", up_rsp_tid, 64'h048);

    // Timeout on port 2, then a late response
    pulseReset();
    upRead(9'h007, 16'h2000);
    step();
    clearInputs();
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (err_timeout[2]) begin
        seen = k;
        break;
      end
    end
    chk("plan_timeout_latency", 64'(seen), 64'(TO));
    step();
    chk("plan_timeout_tid", up_rsp_tid, 64'h007);
    chk("plan_timeout_data", up_rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    subRsp(2, 9'h007, 64'h55);
    step();
    chk("plan_late_mismatch", err_tid_mismatch, 64'h4);
    clearInputs();
    step();
    chk("plan_late_no_rsp", up_rsp_valid, 64'h0);

    // Synthetic and port-1 responses ready together
    pulseReset();
    upRead(9'h020, 16'h1000);
    step();
    clearInputs();
    step();
    upRead(9'h0AA, 16'hF000);
    subRsp(1, 9'h020, 64'h1234);
    step();
    clearInputs();
    step();
    chk("plan_collide_first", up_rsp_tid, 64'h0AA);
    step();
    chk("plan_collide_second", up_rsp_tid, 64'h020);
    chk("plan_collide_data", up_rsp_data, 64'h1234);

    // Mid-operation reset discards outstanding reads
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      upRead(9'(9'h031 + i), 16'(i << WB));
      step();
    end
    clearInputs();
    step();
    pulseReset();
    for (int i = 0; i < 3; i++) subRsp(i, 9'(9'h031 + i), 64'(i));
    step();
    chk("plan_midrst_mismatch", err_tid_mismatch, 64'h7);
    clearInputs();
    step();
    chk("plan_midrst_no_rsp", up_rsp_valid, 64'h0);
    step();

    // Random traffic against the model, with a reset dropped in mid-stream
    for (int c = 0; c < 1500; c++) begin
      clearInputs();
      rspPct = (c < 800) ? 40 : 8;
      SoftReset_n = (c == 600) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) < 60) begin
        upRead(9'($urandom), 16'(($urandom_range(0, 5) << WB) | $urandom_range(0, 4095)));
      end
      for (int i = 0; i < N; i++) begin
        if (mOq[i].size() > 0 && $urandom_range(0, 99) < rspPct)
          subRsp(i, mOq[i][0], {$urandom(), $urandom()});
        else if ($urandom_range(0, 99) < 3)
          subRsp(i, 9'($urandom), {$urandom(), $urandom()});
      end
      step();
    end
    clearInputs();
    SoftReset_n = 1'b1;
    for (int k = 0; k < 60; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
